zero_one_pattern_tx: RTL

Serial bit-stream transmitter that is the driving end of the zero-one detection path. It accepts parallel words over a valid/ready handshake and shifts them out MSB-first on a single-bit line (A), one bit per clk. It also counts every 0->1 transition it puts on the line, so that count equals the number of hits a downstream zero-one detector must report. It is used as the stimulus source for the detector in system tests and as a standalone serial pattern source.

---
 rtl/zero_one_pkg.sv | 16 +
 rtl/rise_counter.sv | 35 +++
 rtl/zero_one_pattern_tx.sv | 102 ++++++++++
 3 files changed

// File: rtl/zero_one_pkg.sv
// Shared types and helpers for the zero-one pattern transmitter and its rise counter.
package zero_one_pkg;

   typedef enum logic {
      StIdle  = 1'b0,
      StShift = 1'b1
   } state_e;

   localparam logic LineIdle = 1'b0;

   // Bit-index counter width for a WIDTH-bit word; never narrower than one bit.
   function automatic int unsigned bit_cnt_width(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/rise_counter.sv
// Saturating counter of 0->1 transitions between the current and next value of a line.
module rise_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             cur_bit,
   input  logic             next_bit,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      // Clear wins over a simultaneous rise, so that rise is lost.
      if (clr) begin
         count_d = '0;
      end else if (!cur_bit && next_bit && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/zero_one_pattern_tx.sv
// MSB-first serializer with a valid/ready load port and a count of the 0->1 edges it drives.
module zero_one_pattern_tx
   import zero_one_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             A,
   output logic             busy,
   output logic             word_done,
   input  logic             clr_hits,
   output logic [CNT_W-1:0] exp_hits
);

   localparam int unsigned BitCntW = bit_cnt_width(WIDTH);
   localparam logic [BitCntW-1:0] LastIdx = BitCntW'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [BitCntW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]   sreg_q, sreg_d;
   logic               a_q, a_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         sreg_q  <= '0;
         a_q     <= LineIdle;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sreg_q  <= sreg_d;
         a_q     <= a_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign accept = load_valid && load_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sreg_d  = sreg_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StShift;
               cnt_d   = LastIdx;
               sreg_d  = din;
            end
         end
         StShift: begin
            if (cnt_q != '0) begin
               sreg_d = sreg_q << 1;
               cnt_d  = cnt_q - 1'b1;
            end else if (accept) begin
               cnt_d  = LastIdx;
               sreg_d = din;
            end else begin
               state_d = StIdle;
               sreg_d  = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Registered outputs are derived from the next state so they line up with it.
   always_comb begin
      load_ready = !rst && ((state_q == StIdle) || (cnt_q == '0));
      busy_d     = (state_d == StShift);
      a_d        = busy_d ? sreg_d[WIDTH-1] : LineIdle;
      done_d     = busy_d && (cnt_d == '0);
   end

   rise_counter #(
      .CNT_W (CNT_W)
   ) u_rise_counter (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr_hits),
      .cur_bit  (a_q),
      .next_bit (a_d),
      .count    (exp_hits)
   );

   assign A         = a_q;
   assign busy      = busy_q;
   assign word_done = done_q;

endmodule
